// File: rtl/rr_mux_n_pkg.sv
// Shared constants, output-register state encoding and the rotate-priority pick used by rr_arbiter.
// rr_pick works on a zero-padded request vector, so wrap-around needs no knowledge of N.
package rr_mux_pkg;

  localparam int RR_MUX_DEF_N = 4;
  localparam int RR_MUX_DEF_W = 8;
  localparam int RR_MUX_MAX_N = 32;
  localparam int RR_MUX_IDX_W = $clog2(RR_MUX_MAX_N);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic                    found;
    logic [RR_MUX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Lowest requester at or above ptr wins; otherwise the lowest requester overall (the wrap).
  function automatic rr_pick_t rr_pick(input logic [RR_MUX_MAX_N-1:0] valid,
                                       input logic [RR_MUX_IDX_W-1:0] ptr);
    rr_pick_t lo;
    rr_pick_t hi;
    lo = '0;
    hi = '0;
    for (int i = RR_MUX_MAX_N - 1; i >= 0; i--) begin
      if (valid[i]) begin
        lo.found = 1'b1;
        lo.idx   = RR_MUX_IDX_W'(i);
        if (i >= int'(ptr)) begin
          hi.found = 1'b1;
          hi.idx   = RR_MUX_IDX_W'(i);
        end
      end
    end
    return hi.found ? hi : lo;
  endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// N producer streams in, one registered stream out; slave is the mux side, master the environment side.
interface rr_mux_n_if
  import rr_mux_pkg::*;
#(
  parameter  int N     = RR_MUX_DEF_N,
  parameter  int W     = RR_MUX_DEF_W,
  localparam int SEL_W = $clog2(N)
);

  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic [SEL_W-1:0] out_sel;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );

endinterface

// File: rtl/rr_mux_n_arbiter.sv
// Combinational rotate-priority arbiter: one-hot grant to the first requester at or after ptr, wrapping.
// Zero latency, no state; any=0 when nothing is requested.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N     = RR_MUX_DEF_N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  rr_pick_t pick;

  always_comb begin
    pick = rr_pick(RR_MUX_MAX_N'(req), RR_MUX_IDX_W'(ptr));
    any  = pick.found;
    for (int i = 0; i < N; i++) begin
      gnt[i] = pick.found && (pick.idx == RR_MUX_IDX_W'(i));
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = SEL_W'(i);
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// Round-robin N:1 stream mux with one output register: 1-cycle latency, 1 beat/cycle, in_ready drops while FULL and stalled.
// Define RR_MUX_LOCK_EN to hold the grant on one channel until its in_last beat (packet lock).
module rr_mux_n
  import rr_mux_pkg::*;
#(
  parameter  int N     = RR_MUX_DEF_N,
  parameter  int W     = RR_MUX_DEF_W,
  localparam int SEL_W = $clog2(N)
) (
  input  logic    clk,
  input  logic    rst_n,
  rr_mux_n_if.slave bus
);

  out_state_e       state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic             last_q, last_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]     arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;

  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] g_idx;
  logic             g_any;
  logic             load;
  logic [N-1:0]     in_ready;
  logic             xfer;
  logic [W-1:0]     g_data;
  logic             g_last;
  logic [SEL_W-1:0] ptr_next;

  rr_arbiter #(.N(N)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

`ifdef RR_MUX_LOCK_EN
  logic             locked_q, locked_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

  // A locked channel keeps the grant even while idle, so other producers cannot interleave mid-packet.
  assign gnt   = locked_q ? (N'(1) << lock_ch_q) : arb_gnt;
  assign g_idx = locked_q ? lock_ch_q : arb_idx;
  assign g_any = locked_q | arb_any;
`else
  assign gnt   = arb_gnt;
  assign g_idx = arb_idx;
  assign g_any = arb_any;
`endif

  assign load          = (state_q == ST_EMPTY) || bus.out_ready;
  assign in_ready      = {N{rst_n & load & g_any}} & gnt;
  assign bus.in_ready  = in_ready;
  assign xfer          = |(bus.in_valid & in_ready);
  assign g_data        = bus.in_data[g_idx*W +: W];
  assign g_last        = bus.in_last[g_idx];
  assign ptr_next      = (g_idx == SEL_W'(N - 1)) ? '0 : g_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (!xfer && bus.out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    bus.out_valid = (state_q == ST_FULL);
    bus.out_data  = data_q;
    bus.out_last  = last_q;
    bus.out_sel   = sel_q;
  end

  always_comb begin
    data_d = data_q;
    last_d = last_q;
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      data_d = g_data;
      last_d = g_last;
      sel_d  = g_idx;
      ptr_d  = ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      last_q <= 1'b0;
      sel_q  <= '0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      last_q <= last_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
    end
  end

`ifdef RR_MUX_LOCK_EN
  always_comb begin
    locked_d  = locked_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      locked_d  = !g_last;
      lock_ch_d = g_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked_q  <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      locked_q  <= locked_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n (N=4, W=8); expectations follow RR_MUX_LOCK_EN when it is defined.
module tb_rr_mux_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rr_mux_n_if #(.N(4), .W(8)) bus ();

  rr_mux_n #(.N(4), .W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

`ifdef RR_MUX_LOCK_EN
  int exp_sel[5]  = '{1, 1, 1, 2, 0};
  int exp_last[5] = '{0, 0, 1, 1, 1};
  logic [3:0] exp_probe = 4'b0010;
`else
  int exp_sel[5]  = '{1, 2, 0, 1, 2};
  int exp_last[5] = '{0, 1, 1, 1, 1};
  logic [3:0] exp_probe = 4'b0100;
`endif

  initial begin
    bus.in_valid  = 4'b1111;
    bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.in_last   = 4'b1111;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // reset
    tick();
    tick();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("rst_out_sel", 32'(bus.out_sel), 32'h0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'h00);
    check_eq("rst_out_last", 32'(bus.out_last), 32'h0);

    // single beat on ch2
    rst_n        = 1'b1;
    bus.in_valid = 4'b0100;
    bus.in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    #1;
    check_eq("single_in_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    check_eq("single_valid", 32'(bus.out_valid), 32'h1);
    check_eq("single_data", 32'(bus.out_data), 32'hA5);
    check_eq("single_sel", 32'(bus.out_sel), 32'h2);
    bus.in_valid = 4'b0000;
    #1;
    check_eq("idle_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check_eq("single_drained", 32'(bus.out_valid), 32'h0);

    // round-robin over all four channels, no bubbles
    rst_n = 1'b0;
    tick();
    rst_n        = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq($sformatf("rr_valid%0d", k), 32'(bus.out_valid), 32'h1);
      check_eq($sformatf("rr_sel%0d", k), 32'(bus.out_sel), 32'(k % 4));
      check_eq($sformatf("rr_data%0d", k), 32'(bus.out_data), 32'(8'h10 + k % 4));
    end

    // mid-stream reset with ptr at 2
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check_eq("midrst_valid", 32'(bus.out_valid), 32'h0);
    check_eq("midrst_ptr", 32'(dut.ptr_q), 32'h0);
    check_eq("midrst_sel", 32'(bus.out_sel), 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_first_ready", 32'(bus.in_ready), 32'b0001);
    tick();
    check_eq("midrst_first_sel", 32'(bus.out_sel), 32'h0);
    check_eq("midrst_first_data", 32'(bus.out_data), 32'h10);

    // backpressure while holding ch1
    tick();
    check_eq("bp_sel_before", 32'(bus.out_sel), 32'h1);
    bus.out_ready = 1'b0;
    #1;
    check_eq("bp_in_ready", 32'(bus.in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("bp_valid%0d", k), 32'(bus.out_valid), 32'h1);
      check_eq($sformatf("bp_sel%0d", k), 32'(bus.out_sel), 32'h1);
      check_eq($sformatf("bp_data%0d", k), 32'(bus.out_data), 32'h11);
      check_eq($sformatf("bp_ready%0d", k), 32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(bus.in_ready), 32'b0100);
    tick();
    check_eq("bp_release_sel", 32'(bus.out_sel), 32'h2);
    check_eq("bp_release_data", 32'(bus.out_data), 32'h12);

    // packet lock: ch1 sends 3 beats, last on the third, with ch0/ch2 competing
    rst_n        = 1'b0;
    bus.in_valid = 4'b0001;
    bus.in_last  = 4'b1111;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("lock_pre_sel", 32'(bus.out_sel), 32'h0);
    bus.in_valid = 4'b0111;
    bus.in_last  = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("lock_sel%0d", k), 32'(bus.out_sel), 32'(exp_sel[k]));
      check_eq($sformatf("lock_last%0d", k), 32'(bus.out_last), 32'(exp_last[k]));
      if (k == 0) begin
        bus.in_valid = 4'b0101;
        #1;
        check_eq("lock_idle_owner", 32'(bus.in_ready), 32'(exp_probe));
        bus.in_valid = 4'b0111;
      end
      if (k == 1) bus.in_last = 4'b0111;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux_n.md
# rr_mux_n

Parametrised N-channel, W-bit round-robin stream multiplexer with a valid/ready handshake per channel and one registered output stage. It generalises the fixed 4:1 single-bit select mux. Selection is owned by an internal fair arbiter rather than an external `sel`, and the block supports backpressure. It sits between several producer streams and one shared consumer.

## Interface
- `N`, 4: number of input channels; N >= 2
- `W`, 8: data width per channel
- `SEL_W`, `$clog2(N)`: width of `out_sel`; derived, not overridden
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  N  per-channel valid
- `in_ready`  out  N  per-channel ready; combinational
- `in_data`  in  N*W  channel i occupies bits [i*W +: W]
- `in_last`  in  N  end-of-packet marker; used only with lock enabled
- `out_valid`  out  1  output register holds a beat
- `out_ready`  in  1  consumer accepts the beat
- `out_data`  out  W  registered data
- `out_last`  out  1  registered copy of the accepted `in_last`
- `out_sel`  out  SEL_W  index of the channel the beat came from

## Operation
- One clock domain; reset is synchronous and active-low.
- Output register states:
  - EMPTY (`out_valid`=0)
  - FULL (`out_valid`=1)
- `load` = !`out_valid` || `out_ready`.
- Arbitration:
  - `grant` = the first i with `in_valid`[i], searching from `ptr` upward and wrapping modulo N.
  - No grant when all `in_valid` are 0.
- `in_ready`[i] = `rst_n` && `load` && `grant`[i]. At most one bit of `in_ready` is set.
- Transfer on channel g happens when `in_valid`[g] && `in_ready`[g]. On that edge:
  - `out_data`/`out_last`/`out_sel` <= the channel-g values
  - `out_valid` <= 1
  - `ptr` <= (g+1) mod N
- If `out_ready` && `out_valid` and there is no transfer, `out_valid` <= 0.
- Simultaneous drain and transfer: the register is overwritten and `out_valid` stays 1, so there is no bubble.
- While FULL and `out_ready`=0, all outputs and `ptr` hold, and `in_ready`=0.
- Input data is not required to be stable before its transfer.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_sel`=0
  - `ptr`=0, lock state clear
  - `in_ready`=0 in every cycle where `rst_n`=0
- Latency: a beat accepted at edge k appears on `out_*` after edge k; it is consumed at the first later edge with `out_ready`=1.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Fairness: with all N channels continuously valid, each channel is granted exactly once every N transfers.
- Reset asserted mid-operation: the output beat is dropped, and the state equals the reset values after the edge.
- `ptr` wrap: when g = N-1, `ptr` becomes 0.

## Configuration
- Macro `RR_MUX_LOCK_EN`.
- Defined:
  - A transfer with `in_last`=0 sets `locked`=1 and `lock_ch`=g.
  - While locked, `grant` is forced to `lock_ch`, even if `in_valid`[`lock_ch`]=0; other channels wait.
  - A transfer with `in_last`=1 from `lock_ch` clears `locked` and sets `ptr` = (`lock_ch`+1) mod N.
  - Reset clears `locked`.
- Undefined:
  - `in_last` is still registered into `out_last` but does not affect arbitration.
  - No lock state exists.

## Structure
- Package `rr_mux_pkg`:
  - default constants `RR_MUX_DEF_N`=4 and `RR_MUX_DEF_W`=8
  - function `rr_pick(valid, ptr)` returning the grant index and a found flag
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs `req`[N], `ptr`[SEL_W]
  - outputs `gnt`[N] one-hot, `gnt_idx`[SEL_W], `any`
  - purely combinational rotate-priority pick, reusable elsewhere
- The top level holds the output register, `ptr` and the lock state.

## Test plan
Bench uses N=4, W=8.
1. Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=4'b1111 -> `in_ready`=0000, `out_valid`=0, `out_sel`=0, `out_data`=8'h00.
2. Single beat: `in_valid`=0100, ch2 data 8'hA5, `out_ready`=1 -> next cycle `out_valid`=1, `out_data`=A5, `out_sel`=2; the following cycle `out_valid`=0.
3. Round-robin: all four channels valid for 8 cycles, data = 8'h10+i, `out_ready`=1 -> `out_sel` sequence 0,1,2,3,0,1,2,3 with no bubbles.
4. Backpressure: `out_ready`=0 for 3 cycles while FULL with `out_sel`=1 -> `out_data` stable, `in_ready`=0000; raise `out_ready` -> next grant is ch2.
5. Lock (`RR_MUX_LOCK_EN`): ch1 sends 3 beats, with `in_last` only on the 3rd, while ch0 and ch2 are valid -> `out_sel` 1,1,1 then 2, then 0. Without the macro the same stimulus gives 1,2,0,1,...
6. Mid-stream reset: drive `rst_n`=0 for one cycle during test 3 -> after that edge `out_valid`=0 and `ptr`=0; after release the first grant is ch0.
